// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - ULA control codes that select the long operations (mul, div, rem)
//   - sequencer state encoding
//   - divide-by-zero result constant
//   - helper that decides whether a ULActl code belongs to the sequencer
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

    // Same codes the ULA control decoder emits for the long operations.
    localparam logic [4:0] ULA_MUL = 5'b00100;
    localparam logic [4:0] ULA_DIV = 5'b00101;
    localparam logic [4:0] ULA_REM = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide by zero: every quotient bit is this value (all-ones quotient).
    // The remainder of a divide by zero is the dividend itself, which the
    // restoring loop produces without any special handling.
    localparam logic DIV0_QUOT_BIT = 1'b1;

    function automatic logic is_muldiv_op(input logic [4:0] ctl);
        return (ctl == ULA_MUL) || (ctl == ULA_DIV) || (ctl == ULA_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the sequencer datapath.
//   mul : acc += opnd when aux[0] is set; aux >>= 1; opnd <<= 1
//         (acc = partial product, aux = multiplier, opnd = multiplicand)
//   div : shift {acc, aux} left by one, trial-subtract opnd from acc;
//         on a non-negative result keep it and shift a 1 into aux, else a 0
//         (acc = partial remainder, aux = dividend becoming quotient,
//          opnd = divisor)
// Ports:
//   i_mul   1      select multiply step (else divide step)
//   i_acc   WIDTH  accumulator in
//   i_aux   WIDTH  multiplier / dividend-quotient in
//   i_opnd  WIDTH  multiplicand / divisor in
//   o_acc, o_aux, o_opnd   next values of the same registers
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_mul,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_aux,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_aux,
    output logic [WIDTH-1:0] o_opnd
);

    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH-1:0] w_diff;

    // The shifted remainder is WIDTH+1 bits wide; the compare uses all of
    // them. When it is >= divisor the true difference is below the divisor,
    // so the low WIDTH bits of the subtraction are exact.
    assign w_rem_sh = {i_acc[WIDTH-2:0], i_aux[WIDTH-1]};
    assign w_ge     = ({i_acc, i_aux[WIDTH-1]} >= {1'b0, i_opnd});
    assign w_diff   = w_rem_sh - i_opnd;

    always_comb begin
        o_acc  = i_acc;
        o_aux  = i_aux;
        o_opnd = i_opnd;
        if (i_mul) begin
            if (i_aux[0]) begin
                o_acc = i_acc + i_opnd;
            end
            o_aux  = i_aux >> 1;
            o_opnd = i_opnd << 1;
        end else begin
            if (w_ge) begin
                o_acc = w_diff;
                o_aux = {i_aux[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_rem_sh;
                o_aux = {i_aux[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative multiply/divide sequencer beside the single-cycle ULA. Accepts a
// mul/div/rem request, runs WIDTH shift-add or restoring-divide steps and
// holds the pipeline stalled until the result is ready.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : two's-complement operands; magnitudes at capture, sign fix at
//               the end (quotient sign = signA^signB, remainder = dividend sign)
//   undefined : unsigned only, no sign-fix logic
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled in IDLE or DONE only
//   ULActl [4:0] in   operation code (mul/div/rem; others ignored)
//   flush        in   abort a running operation
//   opA, opB     in   multiplicand/dividend, multiplier/divisor
//   busy         out  iteration in progress (registered)
//   stall        out  busy | (start & valid op & ~busy), combinational
//   done         out  one-cycle pulse, result valid
//   result       out  low product / quotient / remainder, held
//   o_dbg_state  out  current FSM state for observation
//
// Handshake: a request is taken on a rising edge when start is high, ULActl
// is a long op and the FSM is in IDLE, or in DONE without flush. There is no
// backpressure on the result side: done is a single-cycle pulse and result
// stays until the next accepted request.
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       ULActl,
    input  logic             flush,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output state_t           o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_mul;
    logic             r_is_rem;
    logic             r_div0;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_aux;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_valid_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_aux;
    logic [WIDTH-1:0] w_step_opnd;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fixed;
    logic [WIDTH-1:0] w_final;

    assign w_valid_op = is_muldiv_op(ULActl);
    // In DONE a simultaneous flush suppresses the new request.
    assign w_accept   = start && w_valid_op &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_DONE) && !flush));

`ifdef MULDIV_SIGNED_EN
    logic r_sign_a;
    logic r_sign_b;
    logic w_neg;

    // -2^(WIDTH-1) maps onto itself, which reads correctly as an unsigned
    // magnitude of 2^(WIDTH-1).
    assign w_mag_a = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
    assign w_mag_b = opB[WIDTH-1] ? (~opB + 1'b1) : opB;
    assign w_neg   = r_is_rem ? r_sign_a : (r_sign_a ^ r_sign_b);
    assign w_fixed = w_neg ? (~w_raw + 1'b1) : w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (w_accept) begin
            r_sign_a <= opA[WIDTH-1];
            r_sign_b <= opB[WIDTH-1];
        end
    end
`else
    assign w_mag_a = opA;
    assign w_mag_b = opB;
    assign w_fixed = w_raw;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mul  (r_is_mul),
        .i_acc  (r_acc),
        .i_aux  (r_aux),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_aux  (w_step_aux),
        .o_opnd (w_step_opnd)
    );

    // Result of the final step: product and remainder live in acc, the
    // quotient in aux. Divide by zero forces the all-ones quotient even when
    // the sign fix would otherwise flip it.
    always_comb begin
        w_raw   = (r_is_mul || r_is_rem) ? w_step_acc : w_step_aux;
        w_final = w_fixed;
        if (r_div0 && !r_is_mul && !r_is_rem) begin
            w_final = {WIDTH{DIV0_QUOT_BIT}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_div0   <= 1'b0;
            r_acc    <= '0;
            r_aux    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_is_mul <= (ULActl == ULA_MUL);
                        r_is_rem <= (ULActl == ULA_REM);
                        r_div0   <= (opB == '0);
                        r_acc    <= '0;
                        if (ULActl == ULA_MUL) begin
                            r_aux  <= w_mag_b;
                            r_opnd <= w_mag_a;
                        end else begin
                            r_aux  <= w_mag_a;
                            r_opnd <= w_mag_b;
                        end
                        r_cnt   <= CW'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc  <= w_step_acc;
                        r_aux  <= w_step_aux;
                        r_opnd <= w_step_opnd;
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign stall       = r_busy | (start & w_valid_op & ~r_busy);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed vector table for mul/div/rem plus hand-written sequences for
// flush, reset mid-run, invalid op and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  ULActl;
    logic        flush;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    state_t      dbg_state;

    int checks;
    int errors;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ULActl      (ULActl),
        .flush       (flush),
        .opA         (opA),
        .opB         (opB),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result      (result),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Drives a request, follows it to the done cycle
    // and returns at the negedge inside the done cycle with start low.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string name);
        int cycles;
        int stall_cnt;
        start  = 1'b1;
        ULActl = op;
        opA    = a;
        opB    = b;
        stall_cnt = 0;
        #1;
        if (stall) stall_cnt++;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            if (stall) stall_cnt++;
            @(negedge clk);
            cycles++;
        end
        chk({name, " latency"}, cycles, 33);
        chk({name, " done"}, {31'd0, done}, 32'd1);
        chk({name, " result"}, result, exp);
        chk({name, " stall_done_cycle"}, {31'd0, stall}, 32'd0);
        chk({name, " stall_cycles"}, stall_cnt, 33);
    endtask

    initial begin
        logic [31:0] held;
        int          seen_done;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        ULActl = 5'd0;
        opA    = '0;
        opB    = '0;

        vecs.push_back('{ULA_MUL, 32'd7,   32'd6, 32'd42,         "mul_7x6"});
        vecs.push_back('{ULA_DIV, 32'd100, 32'd7, 32'd14,         "div_100_7"});
        vecs.push_back('{ULA_REM, 32'd100, 32'd7, 32'd2,          "rem_100_7"});
        vecs.push_back('{ULA_DIV, 32'd5,   32'd0, 32'hFFFF_FFFF,  "div_by_zero"});
        vecs.push_back('{ULA_REM, 32'd5,   32'd0, 32'd5,          "rem_by_zero"});
        vecs.push_back('{ULA_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul_wrap"});
        vecs.push_back('{ULA_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, "mul_overflow"});
        vecs.push_back('{ULA_DIV, 32'd12345, 32'd1, 32'd12345,    "div_by_one"});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{ULA_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "sdiv_m7_2"});
        vecs.push_back('{ULA_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "srem_m7_2"});
        vecs.push_back('{ULA_MUL, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, "smul_m3_4"});
        vecs.push_back('{ULA_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "sdiv_7_m2"});
        vecs.push_back('{ULA_REM, 32'd7, 32'hFFFF_FFFE, 32'd1,         "srem_7_m2"});
        vecs.push_back('{ULA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "sdiv_min_m1"});
        vecs.push_back('{ULA_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "srem_min_m1"});
        vecs.push_back('{ULA_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "sdiv_m5_0"});
        vecs.push_back('{ULA_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "srem_m5_0"});
`else
        vecs.push_back('{ULA_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "udiv_big"});
        vecs.push_back('{ULA_REM, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, "urem_big"});
        vecs.push_back('{ULA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  "udiv_small_q"});
        vecs.push_back('{ULA_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "urem_small_q"});
`endif

        // reset state
        #12;
        chk("reset_busy",   {31'd0, busy},  32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_stall",  {31'd0, stall}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_state",  {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
            @(negedge clk);
            chk({vecs[i].name, " done_pulse"}, {31'd0, done}, 32'd0);
            chk({vecs[i].name, " held"}, result, vecs[i].exp);
            chk({vecs[i].name, " idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
        end

        // back-to-back: second start issued in the done cycle
        run_op(ULA_MUL, 32'd9, 32'd9, 32'd81, "b2b_first");
        run_op(ULA_DIV, 32'd81, 32'd4, 32'd20, "b2b_second");
        @(negedge clk);

        // invalid op
        start  = 1'b1;
        ULActl = 5'b00010;
        opA    = 32'd3;
        opB    = 32'd3;
        #1;
        chk("invalid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("invalid_busy", {31'd0, busy}, 32'd0);
        chk("invalid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        start = 1'b0;
        @(negedge clk);

        // start during RUN ignored, flush at step 10
        held   = result;
        start  = 1'b1;
        ULActl = ULA_MUL;
        opA    = 32'd11;
        opB    = 32'd13;
        @(negedge clk);
        ULActl = ULA_DIV;
        repeat (9) @(negedge clk);
        chk("run_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",   {31'd0, busy}, 32'd0);
        chk("flush_done",   {31'd0, done}, 32'd0);
        chk("flush_state",  {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("flush_result", result, held);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("flush_no_done", seen_done, 0);

        // flush and start together in DONE: flush wins
        run_op(ULA_REM, 32'd50, 32'd8, 32'd2, "flush_in_done_prep");
        start  = 1'b1;
        flush  = 1'b1;
        ULActl = ULA_MUL;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_in_done_busy", {31'd0, busy}, 32'd0);
        chk("flush_in_done_result", result, 32'd2);

        // reset mid-run
        start  = 1'b1;
        ULActl = ULA_MUL;
        opA    = 32'd5;
        opB    = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   {31'd0, busy},  32'd0);
        chk("rst_mid_done",   {31'd0, done},  32'd0);
        chk("rst_mid_stall",  {31'd0, stall}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(ULA_MUL, 32'd6, 32'd7, 32'd42, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the ULA's long operations (mul, div, rem). It sits beside the single-cycle ULA and accepts an operation when the decoded `ULActl` code selects mul, div or rem. It runs a 32-step shift-add or restoring-divide loop and holds the pipeline stalled until the 32-bit result is ready. Single-cycle ULA operations never pass through it.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `ULActl`  in  5  operation code: 5'b00100 mul, 5'b00101 div, 5'b01001 rem; any other code is ignored.
- `flush`  in  1  abort the current operation (pipeline flush).
- `opA`  in  WIDTH  multiplicand or dividend.
- `opB`  in  WIDTH  multiplier or divisor.
- `busy`  out  1  iteration in progress.
- `stall`  out  1  combinational: `busy | (start & valid_op & ~busy)`.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  low product, quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, with `start` high and a valid op:
  - Capture op, operand magnitudes and sign flags.
  - Load `cnt` = WIDTH-1 and go to RUN.
- A start with an invalid op is ignored; the state does not change.
- RUN, one step per cycle:
  - mul: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift.
  - div/rem: shift the remainder left with the next dividend bit and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
  - `cnt` decrements each step. At `cnt==0`, apply sign fix, register `result` and go to DONE.
- DONE lasts one cycle (`done=1`), then returns to IDLE unless a new start is accepted.
- mul returns the low WIDTH bits of the product; overflow is discarded silently.
- Divide by zero: quotient is all-ones and remainder equals the dividend. No trap.
- `flush` in RUN: go to IDLE next cycle with no `done` pulse; `result` keeps its old value. `flush` in IDLE or DONE has no effect.
- `start` during RUN is ignored, whatever the op.
- If `flush` and `start` are both high in DONE, `flush` wins and the start is not accepted.

## Timing
- Reset values: state IDLE; `busy`, `done`, `stall` = 0; `result` = 0; `cnt` = 0. Reset takes effect immediately, including mid-RUN.
- If `start` is sampled at edge E0, `busy` is high from E0 through E32. `result` and `done` are valid in the cycle after E32, which is 33 cycles after the start cycle.
- `stall` is high in the start cycle and every RUN cycle, and low in the DONE cycle, so the pipeline consumes `result` there.
- Back-to-back: a start in the DONE cycle is accepted, and the next RUN begins at the following edge.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Operands are two's complement. Magnitudes are taken at capture and the result is negated at the end.
  - Quotient sign is signA^signB; remainder takes the dividend's sign.
  - -2^31 / -1 gives quotient 0x80000000 and remainder 0.
- Undefined: all operations are unsigned and the sign-fix logic is absent.

## Structure
- Shared package:
  - op-code constants `ULA_MUL`, `ULA_DIV`, `ULA_REM` (the same codes the ULA control decoder emits);
  - the state enum (IDLE/RUN/DONE);
  - divide-by-zero result constants.
- One sub-module, `muldiv_step`: purely combinational single iteration (add/shift or trial-subtract/shift) taking op, accumulator and operand. `muldiv_seq` owns the FSM, counter and registers.

## Test plan
- mul: opA=7, opB=6 → `done` 33 cycles after start, `result`=42; `stall` high for exactly 33 cycles.
- div/rem: opA=100, opB=7 → div `result`=14; rem `result`=2.
- Divide by zero: div opA=5, opB=0 → 0xFFFFFFFF; rem opA=5, opB=0 → 5.
- With `MULDIV_SIGNED_EN`: div -7/2 → 0xFFFFFFFD (-3); rem -7/2 → 0xFFFFFFFF (-1); mul -3×4 → 0xFFFFFFF4.
- `flush` at RUN step 10 → IDLE next cycle, no `done`, `result` unchanged. `rst_n` low mid-RUN → all outputs 0 immediately.
- Invalid-op start (ULActl=5'b00010) → `busy` and `stall` stay 0. Back-to-back start in the DONE cycle → second `done` 33 cycles later with the correct result.
